// File: rtl/mr_lsu.sv
// Load/store stage: single-cycle pass-through for ALU results, one outstanding
// req/ack bus transaction for loads and stores with lane steering and timeout.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef REGSEL_BITS
`define REGSEL_BITS 5
`endif
`ifndef MEM_OP_BITS
`define MEM_OP_BITS 2
`endif
`ifndef MEM_SZ_BITS
`define MEM_SZ_BITS 2
`endif
`ifndef MEMOP_NONE
`define MEMOP_NONE  2'd0
`define MEMOP_LOAD  2'd1
`define MEMOP_STORE 2'd2
`endif
`ifndef MEMSZ_B
`define MEMSZ_B 2'd0
`define MEMSZ_H 2'd1
`define MEMSZ_W 2'd2
`endif

module mr_lsu #(
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  // ls_valid/ls_ready: an op transfers on a clock edge where both are high;
  // ls_ready depends on state only, never on ls_valid.
  input  logic                    ls_valid,
  output logic                    ls_ready,
  input  logic [`XLEN-1:0]        ls_dest,
  input  logic [`REGSEL_BITS-1:0] ls_dest_reg,
  input  logic [`MEM_OP_BITS-1:0] ls_memop,
  input  logic [`MEM_SZ_BITS-1:0] ls_size,
  input  logic                    ls_signed,
  input  logic [`XLEN-1:0]        ls_payload,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [`XLEN-1:0]        mem_addr,
  output logic [`XLEN-1:0]        mem_wdata,
  output logic [3:0]              mem_be,
  input  logic                    mem_ack,
  input  logic [`XLEN-1:0]        mem_rdata,
  output logic                    wb_valid,
  output logic [`REGSEL_BITS-1:0] wb_reg,
  output logic [`XLEN-1:0]        wb_data,
  output logic                    misalign,
  output logic                    bus_err,
  output logic [0:0]              dbg_state
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUS = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [TO_BITS-1:0]        count_q;
  logic [`MEM_SZ_BITS-1:0]   size_q;
  logic                      sgn_q;
  logic [1:0]                lane_q;
  logic [`REGSEL_BITS-1:0]   dest_q;

  logic [1:0]                a;
  logic                      is_load, is_store, is_mem, mis;
  logic                      accept, start_bus, ack_hit, to_hit;
  logic [3:0]                st_be;
  logic [`XLEN-1:0]          st_wdata;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;
  logic [`XLEN-1:0]          ld_data;

  assign ls_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_BUS);
  assign dbg_state = state_q;

  always_comb begin
    a         = ls_dest[1:0];
    is_load   = (ls_memop == `MEMOP_LOAD);
    is_store  = (ls_memop == `MEMOP_STORE);
    is_mem    = is_load || is_store;
    mis       = ((ls_size == `MEMSZ_H) && a[0]) ||
                ((ls_size != `MEMSZ_B) && (ls_size != `MEMSZ_H) && (a != 2'b00));
    accept    = ls_valid && (state_q == S_IDLE);
    start_bus = accept && is_mem && !mis;
    ack_hit   = (state_q == S_BUS) && mem_ack;
    // Ack has priority over the timeout on the final allowed cycle.
    to_hit    = (state_q == S_BUS) && !mem_ack &&
                (count_q == TO_BITS'(TIMEOUT - 1));

    state_d = state_q;
    if (start_bus)
      state_d = S_BUS;
    else if (ack_hit || to_hit)
      state_d = S_IDLE;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = ls_payload;
    if (is_store) begin
      case (ls_size)
        `MEMSZ_B: begin
          st_be    = 4'b0001 << a;
          st_wdata = {4{ls_payload[7:0]}};
        end
        `MEMSZ_H: begin
          st_be    = 4'b0011 << a;
          st_wdata = {2{ls_payload[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = ls_payload;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (lane_q)
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      `MEMSZ_B: ld_data = {{(`XLEN-8){sgn_q & ld_byte[7]}}, ld_byte};
      `MEMSZ_H: ld_data = {{(`XLEN-16){sgn_q & ld_half[15]}}, ld_half};
      default:  ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
      wb_valid  <= 1'b0;
      wb_reg    <= '0;
      wb_data   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      size_q    <= '0;
      sgn_q     <= 1'b0;
      lane_q    <= 2'b00;
      dest_q    <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;

      if (accept) begin
        if (!is_mem) begin
          wb_valid <= 1'b1;
          wb_reg   <= ls_dest_reg;
          wb_data  <= ls_dest;
        end else if (mis) begin
          misalign <= 1'b1;
        end else begin
          mem_we    <= is_store;
          mem_addr  <= {ls_dest[`XLEN-1:2], 2'b00};
          mem_wdata <= st_wdata;
          mem_be    <= st_be;
          size_q    <= ls_size;
          sgn_q     <= ls_signed;
          lane_q    <= a;
          dest_q    <= ls_dest_reg;
          count_q   <= '0;
        end
      end

      if (ack_hit) begin
        wb_valid <= !mem_we && (dest_q != '0);
        wb_reg   <= dest_q;
        wb_data  <= ld_data;
      end else if (to_hit) begin
        bus_err <= 1'b1;
      end else if (state_q == S_BUS) begin
        count_q <= count_q + TO_BITS'(1);
      end
    end
  end

endmodule
